// File: rtl/rr_sink_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin sink arbiter.
package rr_sink_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // Burst counter must hold values 0..burst inclusive.
   function automatic int unsigned cnt_width(input int unsigned burst);
      return $clog2(burst + 1);
   endfunction

endpackage

// File: rtl/rr_burst_counter.sv
// Saturating burst counter: clear to 0, load to 1, or step up until it reaches BURST.
module rr_burst_counter #(
   parameter int unsigned BURST = 4,
   parameter int unsigned CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load1,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          at_max_c
);

   localparam logic [CW-1:0] MAX = CW'(BURST);

   assign at_max_c = (count == MAX);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (load1) begin
         count <= CW'(1);
      end else if (inc && !at_max_c) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/rr_sink_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one registered sink between requesters A and B.
module rr_sink_arbiter
   import rr_sink_arbiter_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_a,
   input  logic [W-1:0] data_a,
   input  logic         req_b,
   input  logic [W-1:0] data_b,
   output logic         ack_a,
   output logic         ack_b,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         owner
);

   localparam int unsigned CW = cnt_width(BURST);

   state_t        state;
   logic          last_b;
   logic [CW-1:0] count;
   logic          at_max_c;

   logic          grant_c;
   logic          grant_b_c;
   logic          cnt_clear_c;
   logic          cnt_load1_c;
   logic          cnt_inc_c;
   logic          handover_c;

   // Grant decision for this cycle, from current owner, burst count and requests.
   always_comb begin
      grant_c   = 1'b0;
      grant_b_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_a && req_b) begin
               grant_c   = 1'b1;
               grant_b_c = !last_b;
            end else if (req_a || req_b) begin
               grant_c   = 1'b1;
               grant_b_c = req_b;
            end
         end
         OWN_A: begin
            if (req_a && (!req_b || !at_max_c)) begin
               grant_c = 1'b1;
            end else if (req_b) begin
               grant_c   = 1'b1;
               grant_b_c = 1'b1;
            end
         end
         OWN_B: begin
            if (req_b && (!req_a || !at_max_c)) begin
               grant_c   = 1'b1;
               grant_b_c = 1'b1;
            end else if (req_a) begin
               grant_c = 1'b1;
            end
         end
         default: begin
            grant_c   = 1'b0;
            grant_b_c = 1'b0;
         end
      endcase
   end

   // Leaving an owned state (to the other requester or to IDLE) records who was served.
   assign handover_c  = (state != IDLE) &&
                        (!grant_c || (grant_b_c != (state == OWN_B)));
   assign cnt_clear_c = !grant_c;
   assign cnt_load1_c = grant_c && ((state == IDLE) || handover_c);
   assign cnt_inc_c   = grant_c && !cnt_load1_c;

   rr_burst_counter #(
      .BURST(BURST),
      .CW   (CW)
   ) u_burst_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear_c),
      .load1   (cnt_load1_c),
      .inc     (cnt_inc_c),
      .count   (count),
      .at_max_c(at_max_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_b    <= 1'b1;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         owner     <= REQ_A;
      end else begin
         if (!grant_c) begin
            state <= IDLE;
         end else begin
            state <= grant_b_c ? OWN_B : OWN_A;
         end
         if (handover_c) begin
            last_b <= (state == OWN_B);
         end
         ack_a     <= grant_c && !grant_b_c;
         ack_b     <= grant_c && grant_b_c;
         out_valid <= grant_c;
         owner     <= (grant_c && grant_b_c) ? REQ_B : REQ_A;
         if (!grant_c) begin
            out_data <= '0;
         end else begin
            out_data <= grant_b_c ? data_b : data_a;
         end
      end
   end

endmodule
